// File: rtl/memory_load_sequencer.sv
// Bounded, handshaked RAM block loader with optional read-back checksum verify.
// Ports: clock/reset_N; start/abort control; base_addr/length block window;
//   src_valid/src_data/src_ready byte stream; mem_addr/mem_wr_en/mem_wr_data/
//   mem_rd_data RAM port; busy/done/verify_err/checksum status.
module memory_load_sequencer #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter bit VERIFY_EN = 1'b1
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [2:0] {
      IDLE, LOAD, VERIFY, DRAIN, FINISH
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = 1;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] wsum;
   logic [DATA_W-1:0] rsum;

   logic              in_load;
   logic              in_verify;
   logic              last;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wsum_n;
   logic [DATA_W-1:0] rsum_n;

   assign in_load   = (state == LOAD);
   assign in_verify = (state == VERIFY);
   assign addr      = base + count;
   // length 0 encodes a full 2^ADDR_W block: len-1 wraps to all ones.
   assign last      = (count == len - ONE);
   assign wsum_n    = wsum + src_data;
   assign rsum_n    = rsum + mem_rd_data;

   // Write strobe follows src_valid directly so a beat costs no extra cycle.
   assign src_ready   = in_load;
   assign mem_wr_en   = in_load & src_valid;
   assign mem_wr_data = in_load ? src_data : '0;
   assign mem_addr    = (in_load | in_verify) ? addr : '0;
   assign busy        = (state != IDLE);

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state      <= IDLE;
         base       <= '0;
         len        <= '0;
         count      <= '0;
         wsum       <= '0;
         rsum       <= '0;
         done       <= 1'b0;
         verify_err <= 1'b0;
         checksum   <= '0;
      end else if (abort && state != IDLE) begin
         state <= IDLE;
         count <= '0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base       <= base_addr;
                  len        <= length;
                  count      <= '0;
                  wsum       <= '0;
                  rsum       <= '0;
                  verify_err <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (src_valid) begin
                  wsum <= wsum_n;
                  if (last) begin
                     count <= '0;
                     if (VERIFY_EN) begin
                        state <= VERIFY;
                     end else begin
                        // Status is loaded on entry so it is valid with done.
                        checksum   <= wsum_n;
                        verify_err <= 1'b0;
                        done       <= 1'b1;
                        state      <= FINISH;
                     end
                  end else begin
                     count <= count + ONE;
                  end
               end
            end
            VERIFY: begin
               // Read data lags the address by one cycle; the first
               // address has no datum returning yet.
               if (count != '0) rsum <= rsum_n;
               if (last) begin
                  count <= '0;
                  state <= DRAIN;
               end else begin
                  count <= count + ONE;
               end
            end
            DRAIN: begin
               rsum       <= rsum_n;
               checksum   <= wsum;
               verify_err <= (rsum_n != wsum);
               done       <= 1'b1;
               state      <= FINISH;
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
